// File: rtl/reg_ref_seq.sv
// Register-reference instruction sequencer: expands one opcode-7 instruction into
// a stream of executor control words, one per cycle, MSB operation bit first.
module reg_ref_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] acc_in,
  input  logic        e_in,
  output logic [20:0] control_reg,
  output logic [11:0] ir,
  output logic        ctrl_valid,
  output logic        skip,
  output logic        done,
  output logic        err,
  output logic        halted,
  output logic [1:0]  state_dbg
);

  // Handshake: an instruction transfers on a rising clk where instr_valid and
  // instr_ready are both high; instr_ready is high only while IDLE, and instr
  // is copied into pend_q at that edge so later changes on instr are ignored.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam logic [11:0] MAPPED_MASK = 12'hCFF;

  state_t      state_q, state_d;
  logic [11:0] pend_q, pend_d;
  logic        skip_q, skip_d;
  logic        err_q, err_d;
  logic [3:0]  sel_idx;
  logic        sel_hit;
  logic        legal;
  logic [11:0] masked;

  assign state_dbg = state_q;
  assign err       = err_q;
  assign legal     = (instr[15:12] == 4'b0111) && (instr[11:0] != 12'd0);
  assign masked    = instr[11:0] & MAPPED_MASK;

  // Highest set pending bit wins; the ascending loop lets later hits overwrite.
  always_comb begin
    sel_idx = 4'd0;
    sel_hit = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (pend_q[i]) begin
        sel_idx = i[3:0];
        sel_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pend_q  <= 12'd0;
      skip_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      skip_q  <= skip_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    skip_d      = skip_q;
    err_d       = 1'b0;
    control_reg = 21'd0;
    ir          = 12'd0;
    ctrl_valid  = 1'b0;
    skip        = 1'b0;
    done        = 1'b0;
    halted      = 1'b0;
    instr_ready = 1'b0;
    case (state_q)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          if (legal) begin
            pend_d  = masked;
            skip_d  = 1'b0;
            // Only unmapped bits set: nothing to issue, finish straight away.
            state_d = (masked != 12'd0) ? ISSUE : DONE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        pend_d[sel_idx] = 1'b0;
        case (sel_idx)
          4'd11: begin control_reg = 21'h040004; ctrl_valid = 1'b1; end
          4'd10: begin control_reg = 21'h000024; ctrl_valid = 1'b1; end
          4'd7:  begin control_reg = 21'h020084; ir = 12'h004; ctrl_valid = 1'b1; end
          4'd6:  begin control_reg = 21'h020084; ir = 12'h040; ctrl_valid = 1'b1; end
          4'd5:  begin control_reg = 21'h010004; ctrl_valid = 1'b1; end
          4'd4:  skip_d = skip_q | ~acc_in[15];
          4'd3:  skip_d = skip_q | acc_in[15];
          4'd2:  skip_d = skip_q | (acc_in == 16'd0);
          4'd1:  skip_d = skip_q | ~e_in;
          4'd0:  ctrl_valid = 1'b1;
          default: ;
        endcase
        if (sel_hit && sel_idx == 4'd0) state_d = HALT;
        else if (!sel_hit || pend_d == 12'd0) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        skip    = skip_q;
        state_d = IDLE;
      end
      HALT: begin
        halted = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_reg_ref_seq.sv
// Directed bench for reg_ref_seq with a small accumulator/E executor model.
module tb_reg_ref_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] instr = 16'd0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [15:0] acc_in;
  logic        e_in;
  logic [20:0] control_reg;
  logic [11:0] ir;
  logic        ctrl_valid, skip, done, err, halted;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  logic [15:0] acc_m = 16'h1234;
  logic        e_m = 1'b1;

  assign acc_in = acc_m;
  assign e_in   = e_m;

  always #5 clk = ~clk;

  reg_ref_seq dut (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .acc_in(acc_in), .e_in(e_in),
    .control_reg(control_reg), .ir(ir), .ctrl_valid(ctrl_valid),
    .skip(skip), .done(done), .err(err), .halted(halted), .state_dbg(state_dbg)
  );

  // Executor model: applies the issued words on the clock edge.
  always @(posedge clk) begin
    if (ctrl_valid) begin
      if (control_reg == 21'h040004) acc_m <= 16'd0;
      else if (control_reg == 21'h000024) e_m <= 1'b0;
      else if (control_reg == 21'h010004) acc_m <= acc_m + 16'd1;
      else if (control_reg == 21'h020084 && ir == 12'h004) begin
        acc_m <= {e_m, acc_m[15:1]}; e_m <= acc_m[0];
      end else if (control_reg == 21'h020084 && ir == 12'h040) begin
        acc_m <= {acc_m[14:0], e_m}; e_m <= acc_m[15];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents instr for exactly one cycle, then advances into cycle t+1.
  task automatic accept(input logic [15:0] w);
    instr = w;
    instr_valid = 1'b1;
    chk("ready_at_accept", {31'd0, instr_ready}, 32'd1);
    tick();
    instr_valid = 1'b0;
    instr = 16'hFFFF;
  endtask

  initial begin
    tick(); tick();
    chk("rst_ready", {31'd0, instr_ready}, 32'd1);
    chk("rst_state", {30'd0, state_dbg}, 32'd0);
    chk("rst_outs", {control_reg, ctrl_valid, done, err, halted, skip}, 32'd0);
    reset = 1'b0;
    tick();

    // CLA alone
    accept(16'h7800);
    chk("cla_valid", {31'd0, ctrl_valid}, 32'd1);
    chk("cla_word", {11'd0, control_reg}, 32'h040004);
    chk("cla_ir", {20'd0, ir}, 32'd0);
    chk("cla_ready_busy", {31'd0, instr_ready}, 32'd0);
    tick();
    chk("cla_done", {30'd0, done, skip}, 32'h2);
    chk("cla_done_nocv", {31'd0, ctrl_valid}, 32'd0);
    tick();
    chk("cla_idle", {30'd0, instr_ready, done}, 32'h2);

    // CIR then INC: acc 0,e 1 -> 8000 -> 8001
    accept(16'h70A0);
    chk("cir_word", {11'd0, control_reg}, 32'h020084);
    chk("cir_ir", {20'd0, ir}, 32'h004);
    tick();
    chk("inc_word", {ctrl_valid, 10'd0, control_reg}, 32'h80010004);
    chk("inc_ir", {20'd0, ir}, 32'd0);
    tick();
    chk("cirinc_done", {30'd0, done, skip}, 32'h2);
    tick();

    // SNA on acc=8001 -> skip
    accept(16'h7008);
    chk("sna_nocv", {31'd0, ctrl_valid}, 32'd0);
    tick();
    chk("sna_done", {30'd0, done, skip}, 32'h3);
    tick();

    // SPA on acc=8001 -> no skip; flag must have been cleared
    accept(16'h7010);
    tick();
    chk("spa_done", {30'd0, done, skip}, 32'h2);
    tick();

    // CLA then SZA must see cleared accumulator
    accept(16'h7804);
    chk("clasza_cla", {ctrl_valid, 10'd0, control_reg}, 32'h80040004);
    tick();
    chk("clasza_sza_nocv", {31'd0, ctrl_valid}, 32'd0);
    tick();
    chk("clasza_done", {30'd0, done, skip}, 32'h3);
    tick();

    // Only unmapped bits: legal, immediate done
    accept(16'h7300);
    chk("unmapped_done", {29'd0, done, skip, err}, 32'h4);
    chk("unmapped_nocv", {31'd0, ctrl_valid}, 32'd0);
    tick();
    chk("unmapped_idle", {31'd0, instr_ready}, 32'd1);

    // Illegal opcode and zero operation field
    accept(16'h2005);
    chk("ill1_err", {29'd0, err, ctrl_valid, instr_ready}, 32'h5);
    tick();
    chk("ill1_err_clr", {31'd0, err}, 32'd0);
    accept(16'h7000);
    chk("ill2_err", {29'd0, err, ctrl_valid, instr_ready}, 32'h5);
    tick();
    chk("ill2_err_clr", {31'd0, err}, 32'd0);

    // HLT
    accept(16'h7001);
    chk("hlt_word", {ctrl_valid, 10'd0, control_reg}, 32'h80000000);
    tick();
    chk("hlt_halted", {29'd0, halted, instr_ready, done}, 32'h4);
    instr = 16'h7800;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    chk("hlt_hold", {29'd0, halted, ctrl_valid, instr_ready}, 32'h4);
    chk("hlt_state", {30'd0, state_dbg}, 32'd3);
    reset = 1'b1;
    #1;
    chk("hlt_rst", {30'd0, halted, instr_ready}, 32'h1);
    tick();
    reset = 1'b0;
    tick();

    // Reset mid-issue of 7C20: CLA, CLE, then reset before INC
    accept(16'h7C20);
    chk("mid_cla", {11'd0, control_reg}, 32'h040004);
    tick();
    chk("mid_cle", {11'd0, control_reg}, 32'h000024);
    reset = 1'b1;
    #1;
    chk("mid_rst_outs", {control_reg, ctrl_valid, done, err, halted, skip}, 32'd0);
    chk("mid_rst_ready", {31'd0, instr_ready}, 32'd1);
    tick();
    reset = 1'b0;
    tick();
    chk("mid_no_inc", {31'd0, ctrl_valid}, 32'd0);
    accept(16'h7800);
    chk("post_rst_cla", {ctrl_valid, 10'd0, control_reg}, 32'h80040004);
    tick();
    chk("post_rst_done", {30'd0, done, skip}, 32'h2);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
